// File: rtl/qr_pos_finder.sv
// rtl/qr_pos_finder.sv - raster-stream 7x7 finder pattern detector for the QR decode FIND phase
module qr_pos_finder #(
    parameter int COL_W = 40,
    parameter int ROW_H = 64
) (
    input  logic       clk,
    input  logic       srstn,
    input  logic       start,
    input  logic       pix_valid,
    input  logic       pix_bit,
    input  logic [5:0] pix_row,
    input  logic [5:0] pix_col,
    output logic       pos_find,
    output logic [5:0] find_row,
    output logic [5:0] find_col,
    output logic       no_find
);

    typedef enum logic [1:0] {ROW_N, ROW_A, ROW_B, ROW_C} row_t;

    localparam logic [5:0] LAST_ROW = 6'(ROW_H - 1);
    localparam logic [5:0] LAST_COL = 6'(COL_W - 1);

    logic [6:0] w;
    logic [6:0] w_next;
    logic [2:0] cnt [COL_W];
    logic [2:0] cur_cnt;
    logic [2:0] cnt_next;
    row_t       row_type;
    row_t       exp_type;
    logic       accept;
    logic       col_ok;
    logic       upd;
    logic       hit;
    logic       last_pix;

    always_comb begin
        accept   = pix_valid && !start && !pos_find && !no_find;
        // column 0 restarts the window so no row ever sees the previous row's tail
        w_next   = (pix_col == 6'd0) ? {6'b0, pix_bit} : {w[5:0], pix_bit};
        col_ok   = (pix_col <= LAST_COL);
        upd      = accept && col_ok && (pix_col >= 6'd6);
        cur_cnt  = col_ok ? cnt[pix_col] : 3'd0;
        last_pix = accept && (pix_row == LAST_ROW) && (pix_col == LAST_COL);

        case (w_next)
            7'b1111111: row_type = ROW_A;
            7'b1000001: row_type = ROW_B;
            7'b1011101: row_type = ROW_C;
            default:    row_type = ROW_N;
        endcase

        case (cur_cnt)
            3'd0, 3'd6: exp_type = ROW_A;
            3'd1, 3'd5: exp_type = ROW_B;
            default:    exp_type = ROW_C;
        endcase

        hit      = 1'b0;
        cnt_next = 3'd0;
        if (row_type == exp_type) begin
            if (cur_cnt == 3'd6) begin
                hit = upd;
            end else begin
                cnt_next = cur_cnt + 3'd1;
            end
        end else if (row_type == ROW_A) begin
            // a stray top edge may itself begin a new pattern
            cnt_next = 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!srstn || start) begin
            w        <= 7'd0;
            pos_find <= 1'b0;
            no_find  <= 1'b0;
            find_row <= 6'd0;
            find_col <= 6'd0;
            for (int k = 0; k < COL_W; k++) begin
                cnt[k] <= 3'd0;
            end
        end else if (accept) begin
            w <= w_next;
            if (upd) begin
                cnt[pix_col] <= cnt_next;
            end
            if (hit) begin
                pos_find <= 1'b1;
                find_row <= pix_row;
                find_col <= pix_col;
            end else if (last_pix) begin
                no_find <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_qr_pos_finder.sv
// tb/tb_qr_pos_finder.sv - randomized and directed bench for qr_pos_finder against a 2-D template search model
module tb_qr_pos_finder;

    localparam int COL_W = 40;
    localparam int ROW_H = 64;
    localparam int NPIX  = COL_W * ROW_H;
    localparam int LAST  = NPIX - 1;

    logic       clk = 1'b0;
    logic       srstn = 1'b0;
    logic       start = 1'b0;
    logic       pix_valid = 1'b0;
    logic       pix_bit = 1'b0;
    logic [5:0] pix_row = 6'd0;
    logic [5:0] pix_col = 6'd0;
    logic       pos_find;
    logic [5:0] find_row;
    logic [5:0] find_col;
    logic       no_find;

    int n_vec = 0;
    int n_err = 0;
    bit img [ROW_H][COL_W];

    always #5 clk = ~clk;

    qr_pos_finder #(.COL_W(COL_W), .ROW_H(ROW_H)) dut (
        .clk(clk), .srstn(srstn), .start(start), .pix_valid(pix_valid),
        .pix_bit(pix_bit), .pix_row(pix_row), .pix_col(pix_col),
        .pos_find(pos_find), .find_row(find_row), .find_col(find_col), .no_find(no_find)
    );

    // finder pattern geometry: dark outer ring plus dark 3x3 core
    function automatic bit fp_dark(input int i, input int j);
        return (i == 0 || i == 6 || j == 0 || j == 6) || (i >= 2 && i <= 4 && j >= 2 && j <= 4);
    endfunction

    function automatic bit match_at(input int r, input int c);
        for (int dr = 0; dr < 7; dr++)
            for (int dc = 0; dc < 7; dc++)
                if (img[r-6+dr][c-6+dc] != fp_dark(dr, dc)) return 1'b0;
        return 1'b1;
    endfunction

    // first raster index whose 7x7 window lies entirely in pixels seen since index s
    function automatic int model_find(input int s);
        for (int i = s; i <= LAST; i++) begin
            int r = i / COL_W;
            int c = i % COL_W;
            if (r >= 6 && c >= 6 && ((r - 6) * COL_W + (c - 6)) >= s && match_at(r, c)) return i;
        end
        return -1;
    endfunction

    function automatic int scan_end(input int s);
        int f = model_find(s);
        if (f < 0 || f + COL_W > LAST) return LAST;
        return f + COL_W;
    endfunction

    task automatic clear_img(input int density);
        for (int r = 0; r < ROW_H; r++)
            for (int c = 0; c < COL_W; c++)
                img[r][c] = (density != 0) && ($urandom_range(density - 1) == 0);
    endtask

    task automatic plant(input int r0, input int c0);
        for (int i = 0; i < 7; i++)
            for (int j = 0; j < 7; j++)
                img[r0+i][c0+j] = fp_dark(i, j);
    endtask

    task automatic drive_pix(input int i, input bit with_start);
        @(negedge clk);
        if ($urandom_range(7) == 0) begin
            pix_valid = 1'b0;
            @(negedge clk);
        end
        pix_valid = 1'b1;
        pix_row   = 6'(i / COL_W);
        pix_col   = 6'(i % COL_W);
        pix_bit   = img[i / COL_W][i % COL_W];
        start     = with_start;
        @(posedge clk);
        #1;
        pix_valid = 1'b0;
        start     = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        srstn = 1'b0;
        @(posedge clk);
        #1;
        srstn = 1'b1;
    endtask

    task automatic check_clear(input string tag);
        n_vec += 4;
        if (pos_find !== 1'b0) begin n_err++; $display("FAIL %s pos_find got %b want 0", tag, pos_find); end
        if (no_find !== 1'b0) begin n_err++; $display("FAIL %s no_find got %b want 0", tag, no_find); end
        if (find_row !== 6'd0) begin n_err++; $display("FAIL %s find_row got %0d want 0", tag, find_row); end
        if (find_col !== 6'd0) begin n_err++; $display("FAIL %s find_col got %0d want 0", tag, find_col); end
    endtask

    // drive pixels s..e from a freshly cleared detector and track the flag timeline
    task automatic scan(input int s, input int e, input string tag);
        int f;
        int er;
        int ec;
        bit bad;
        bit exp_p;
        bit exp_n;
        f   = model_find(s);
        bad = 1'b0;
        for (int i = s; i <= e; i++) begin
            drive_pix(i, 1'b0);
            exp_p = (f >= 0) && (i >= f);
            exp_n = (f < 0) && (i == LAST);
            if (!bad && (pos_find !== exp_p || no_find !== exp_n)) begin
                bad = 1'b1;
                n_err++;
                $display("FAIL %s flags after pixel (%0d,%0d): pos_find=%b no_find=%b want %b %b",
                         tag, i / COL_W, i % COL_W, pos_find, no_find, exp_p, exp_n);
            end
        end
        n_vec++;
        er = (f >= 0 && e >= f) ? f / COL_W : 0;
        ec = (f >= 0 && e >= f) ? f % COL_W : 0;
        n_vec += 2;
        if (find_row !== 6'(er)) begin n_err++; $display("FAIL %s find_row got %0d want %0d", tag, find_row, er); end
        if (find_col !== 6'(ec)) begin n_err++; $display("FAIL %s find_col got %0d want %0d", tag, find_col, ec); end
    endtask

    task automatic test_reset();
        srstn = 1'b0;
        start = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_clear("reset");
        start = 1'b0;
        srstn = 1'b1;
    endtask

    task automatic test_corner_patterns();
        clear_img(0); plant(0, 0);
        pulse_start(); scan(0, LAST, "top_left");
        clear_img(0); plant(50, 33);
        pulse_start(); scan(0, LAST, "bottom_right");
        clear_img(0);
        pulse_start(); scan(0, LAST, "empty");
    endtask

    task automatic test_broken_pattern();
        clear_img(0); plant(10, 10);
        for (int j = 0; j < 7; j++) img[13][10+j] = (j == 0 || j == 6);
        pulse_start(); scan(0, LAST, "broken");
    endtask

    task automatic test_two_patterns();
        clear_img(0); plant(5, 20); plant(30, 2);
        pulse_start(); scan(0, LAST, "two_patterns");
    endtask

    // counters left at the last stage must not survive the abort and complete on a lone top edge
    task automatic test_abort(input bit use_reset);
        string tag;
        tag = use_reset ? "reset_abort" : "start_abort";
        clear_img(0); plant(0, 0);
        pulse_start(); scan(0, 300, {tag, "_find"});
        if (use_reset) pulse_reset(); else pulse_start();
        check_clear({tag, "_clear"});
        scan(0, 6 * COL_W - 1, {tag, "_partial"});
        if (use_reset) pulse_reset(); else pulse_start();
        clear_img(0);
        for (int j = 0; j < 7; j++) img[0][j] = 1'b1;
        scan(0, LAST, {tag, "_lone_edge"});
        clear_img(0); plant(0, 0);
        pulse_start(); scan(0, 300, {tag, "_rescan"});
    endtask

    task automatic test_start_drop();
        clear_img(0); plant(0, 0);
        pulse_start(); scan(0, 6 * COL_W + 5, "drop_pre");
        drive_pix(6 * COL_W + 6, 1'b1);
        n_vec++;
        if (pos_find !== 1'b0) begin n_err++; $display("FAIL drop_pixel pos_find got %b want 0", pos_find); end
        scan(6 * COL_W + 7, LAST, "drop_post");
        pulse_start(); scan(0, 300, "drop_rescan");
    endtask

    task automatic test_random();
        int dens [3] = '{0, 8, 2};
        for (int t = 0; t < 10; t++) begin
            int np;
            clear_img(dens[$urandom_range(2)]);
            np = $urandom_range(2);
            for (int p = 0; p < np; p++) begin
                int r0 = $urandom_range(ROW_H - 7);
                int c0 = $urandom_range(COL_W - 7);
                plant(r0, c0);
                if ($urandom_range(2) == 0)
                    img[r0 + $urandom_range(6)][c0 + $urandom_range(6)] ^= 1'b1;
            end
            pulse_start();
            scan(0, scan_end(0), "random");
        end
    endtask

    initial begin
        test_reset();
        test_corner_patterns();
        test_broken_pattern();
        test_two_patterns();
        test_abort(1'b0);
        test_abort(1'b1);
        test_start_drop();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
